// File: rtl/jtpopeye_objdma_if.sv
// CPU-bus side of the object DMA: bus request/acknowledge and the main-RAM read port.
interface jtpopeye_objdma_if #(parameter int AW = 10);
    logic          busrq_n;
    logic          busak_n;
    logic [AW-1:0] AD_DMA;
    logic          dma_cs;
    logic [7:0]    DD_DMA;

    modport master (output busrq_n, AD_DMA, dma_cs, input busak_n, DD_DMA);
    modport slave  (input busrq_n, AD_DMA, dma_cs, output busak_n, DD_DMA);
endinterface

// File: rtl/jtpopeye_objdma.sv
// Object-table DMA: copies OBJN records of OBJW bytes from main RAM on each VB start.
// Define JTPOPEYE_OBJDMA_DBLBUF_EN for a double-buffered table (front swaps only on clean transfers).
module jtpopeye_objdma #(
    parameter int            OBJN  = 64,
    parameter int            OBJW  = 4,
    parameter int            AW    = 10,
    parameter logic [AW-1:0] BASE  = '0,
    parameter int            ACKTO = 255
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pxl_cen,
    input  logic                    VB,
    jtpopeye_objdma_if.master       bus,
    input  logic [$clog2(OBJN)-1:0] rd_addr,
    output logic [8*OBJW-1:0]       rd_data,
    output logic                    busy,
    output logic                    err
);
    localparam int NB = OBJN * OBJW;
    localparam int IW = $clog2(OBJN);
    localparam int BW = $clog2(NB) + 1;
    localparam int TW = (ACKTO < 2) ? 1 : $clog2(ACKTO + 1);
    localparam int RW = 8 * OBJW;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] REL   = 3'd4;

    logic [2:0]    st;
    logic          vb_l;
    logic [BW-1:0] bcnt;
    logic [IW-1:0] rcnt;
    logic [2:0]    bpos;
    logic [TW-1:0] tocnt;
    logic [RW-1:0] rec_buf;
    logic [RW-1:0] rec_next;
    logic          vb_rise;
    logic          xfer_abort;
    logic          cap;
    logic          tbl_we;

    assign vb_rise    = VB & ~vb_l;
    assign xfer_abort = ~VB | bus.busak_n;
    // Data for the address issued last tick arrives now; nothing is pending on the first XFER tick.
    assign cap        = pxl_cen && ((st == XFER && bcnt != '0 && !xfer_abort) || st == DRAIN);
    assign tbl_we     = cap && (bpos == 3'(OBJW - 1));

    assign busy        = (st == REQ) || (st == XFER) || (st == DRAIN);
    assign bus.busrq_n = ~busy;
    assign bus.dma_cs  = (st == XFER);
    assign bus.AD_DMA  = BASE + AW'(bcnt);

    always_comb begin
        rec_next = rec_buf;
        rec_next[8*bpos +: 8] = bus.DD_DMA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            vb_l    <= 1'b0;
            bcnt    <= '0;
            rcnt    <= '0;
            bpos    <= '0;
            tocnt   <= '0;
            rec_buf <= '0;
            err     <= 1'b0;
        end else if (pxl_cen) begin
            vb_l <= VB;
            if (cap) begin
                rec_buf <= rec_next;
                if (tbl_we) begin
                    bpos <= '0;
                    rcnt <= rcnt + 1'b1;
                end else begin
                    bpos <= bpos + 3'd1;
                end
            end
            case (st)
                IDLE: begin
                    if (vb_rise) begin
                        st    <= REQ;
                        err   <= 1'b0;
                        bcnt  <= '0;
                        rcnt  <= '0;
                        bpos  <= '0;
                        tocnt <= '0;
                    end
                end
                REQ: begin
                    if (!bus.busak_n) begin
                        st <= XFER;
                    end else if (!VB || tocnt == TW'(ACKTO)) begin
                        st  <= REL;
                        err <= 1'b1;
                    end else begin
                        tocnt <= tocnt + 1'b1;
                    end
                end
                // A lost bus or early VB end leaves the partial record unwritten.
                XFER: begin
                    if (xfer_abort) begin
                        st  <= REL;
                        err <= 1'b1;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == BW'(NB - 1)) st <= DRAIN;
                    end
                end
                DRAIN:   st <= REL;
                REL:     st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
    logic          front;
    logic [RW-1:0] tbl [2][OBJN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) front <= 1'b0;
        else if (pxl_cen && st == REL && !err) front <= ~front;
    end

    always_ff @(posedge clk) begin
        if (tbl_we) tbl[~front][rcnt] <= rec_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= tbl[front][rd_addr];
    end
`else
    logic [RW-1:0] tbl [OBJN];

    always_ff @(posedge clk) begin
        if (tbl_we) tbl[rcnt] <= rec_next;
    end

    // Read-before-write: a same-cycle read of the written index returns old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= tbl[rd_addr];
    end
`endif
endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Randomized bench for jtpopeye_objdma against a record-level table model.
module tb_jtpopeye_objdma;
    localparam int              N     = 4;
    localparam int              W     = 4;
    localparam int              AW    = 10;
    localparam int              ACKTO = 8;
    localparam int              NB    = N * W;
    localparam logic [AW-1:0]   BASE  = 10'h100;
`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pxl_cen = 1'b0;
    logic           VB = 1'b0;
    logic [1:0]     rd_addr = '0;
    logic [8*W-1:0] rd_data;
    logic           busy;
    logic           err;

    jtpopeye_objdma_if #(.AW(AW)) bus();

    jtpopeye_objdma #(.OBJN(N), .OBJW(W), .AW(AW), .BASE(BASE), .ACKTO(ACKTO)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB), .bus(bus),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             fails  = 0;
    int             div    = 1;
    logic [7:0]     ram [1024];
    logic [AW-1:0]  addrq [$];
    bit             addr_glitch = 1'b0;
    logic [AW-1:0]  last_addr = '0;
    bit             last_cen = 1'b1;
    logic [8*W-1:0] mtbl [2][N];
    int             mfront = 0;

    // One clk cycle: RAM answers the address seen at a tick, monitor logs issued addresses.
    task automatic cyc(input bit cen);
        logic [7:0] nxt;
        pxl_cen = cen;
        nxt = ram[bus.AD_DMA];
        if (cen && bus.dma_cs) addrq.push_back(bus.AD_DMA);
        if (!last_cen && bus.AD_DMA !== last_addr) addr_glitch = 1'b1;
        last_addr = bus.AD_DMA;
        last_cen  = cen;
        @(posedge clk);
        #1;
        if (cen) bus.DD_DMA = nxt;
    endtask

    task automatic tick();
        for (int i = 1; i < div; i++) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    endtask

    task automatic vb_rise();
        VB = 1'b0;
        tick();
        tick();
        VB = 1'b1;
        tick();
    endtask

    task automatic ack(input int d);
        repeat (d) tick();
        bus.busak_n = 1'b0;
        tick();
    endtask

    task automatic wait_rel(output int n);
        n = 0;
        while (bus.busrq_n === 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [8*W-1:0] ref_rec(input int r);
        logic [8*W-1:0] v;
        for (int b = 0; b < W; b++) v[8*b +: 8] = ram[(int'(BASE) + r*W + b) % 1024];
        return v;
    endfunction

    task automatic model_frame(input int nrec, input bit ok);
        int wsel;
        wsel = DBL ? 1 - mfront : 0;
        for (int r = 0; r < nrec; r++) mtbl[wsel][r] = ref_rec(r);
        if (ok && DBL) mfront = 1 - mfront;
    endtask

    function automatic bit addr_seq_ok();
        if (addrq.size() != NB) return 1'b0;
        for (int i = 0; i < NB; i++) if (addrq[i] !== AW'(int'(BASE) + i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.busak_n = 1'b1;
        bus.DD_DMA = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busrq_n !== 1'b1) begin fails++; $display("[TB] FAIL reset_busrq_n: got %b expected 1", bus.busrq_n); end
        checks++; if (bus.dma_cs !== 1'b0) begin fails++; $display("[TB] FAIL reset_dma_cs: got %b expected 0", bus.dma_cs); end
        checks++; if (bus.AD_DMA !== BASE) begin fails++; $display("[TB] FAIL reset_AD_DMA: got %h expected %h", bus.AD_DMA, BASE); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (rd_data !== '0) begin fails++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int n;
        for (int it = 0; it < 3; it++) begin
            fill_ram();
            addrq.delete();
            vb_rise();
            checks++; if (bus.busrq_n !== 1'b0) begin fails++; $display("[TB] FAIL nominal_req: busrq_n got %b expected 0", bus.busrq_n); end
            ack($urandom_range(0, 5));
            wait_rel(n);
            checks++; if (n != NB + 1) begin fails++; $display("[TB] FAIL nominal_hold: ticks got %0d expected %0d", n, NB + 1); end
            checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL nominal_err: got %b expected 0", err); end
            checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL nominal_busy: got %b expected 0", busy); end
            checks++; if (!addr_seq_ok()) begin fails++; $display("[TB] FAIL nominal_addr: %0d addresses, first %h, expected %0d from %h", addrq.size(), (addrq.size() > 0) ? addrq[0] : '0, NB, BASE); end
            bus.busak_n = 1'b1;
            tick();
            model_frame(N, 1'b1);
            for (int i = 0; i < N; i++) begin
                rd_addr = 2'(i);
                cyc(1'b0);
                checks++; if (rd_data !== mtbl[mfront][i]) begin fails++; $display("[TB] FAIL nominal_rec%0d: got %h expected %h", i, rd_data, mtbl[mfront][i]); end
            end
        end
    endtask

    task automatic test_ack_timeout();
        int n;
        vb_rise();
        n = 0;
        while (bus.busrq_n === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        checks++; if (n != ACKTO + 1) begin fails++; $display("[TB] FAIL timeout_req_len: got %0d expected %0d", n, ACKTO + 1); end
        checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_err: got %b expected 1", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
        tick();
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            cyc(1'b0);
            checks++; if (rd_data !== mtbl[mfront][i]) begin fails++; $display("[TB] FAIL timeout_rec%0d: got %h expected %h", i, rd_data, mtbl[mfront][i]); end
        end
    endtask

    task automatic test_vb_abort();
        fill_ram();
        vb_rise();
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL abort_err_clear: got %b expected 0", err); end
        ack($urandom_range(0, 5));
        repeat (7) tick();
        VB = 1'b0;
        tick();
        checks++; if (bus.busrq_n !== 1'b1) begin fails++; $display("[TB] FAIL abort_busrq_n: got %b expected 1", bus.busrq_n); end
        checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL abort_err: got %b expected 1", err); end
        bus.busak_n = 1'b1;
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL abort_err_sticky: got %b expected 1", err); end
        model_frame(1, 1'b0);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            cyc(1'b0);
            checks++; if (rd_data !== mtbl[mfront][i]) begin fails++; $display("[TB] FAIL abort_rec%0d: got %h expected %h", i, rd_data, mtbl[mfront][i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        div = 2;
        fill_ram();
        addrq.delete();
        vb_rise();
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL b2b_err_clear: got %b expected 0", err); end
        ack($urandom_range(0, 5));
        repeat (4) tick();
        VB = 1'b0;
        cyc(1'b0);
        VB = 1'b1;
        cyc(1'b1);
        wait_rel(n);
        checks++; if (n + 5 != NB + 1) begin fails++; $display("[TB] FAIL b2b_hold: ticks got %0d expected %0d", n + 5, NB + 1); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL b2b_err: got %b expected 0", err); end
        checks++; if (!addr_seq_ok()) begin fails++; $display("[TB] FAIL b2b_addr: %0d addresses, expected %0d", addrq.size(), NB); end
        bus.busak_n = 1'b1;
        repeat (5) tick();
        checks++; if (bus.busrq_n !== 1'b1) begin fails++; $display("[TB] FAIL b2b_retrigger: busrq_n got %b expected 1", bus.busrq_n); end
        model_frame(N, 1'b1);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            cyc(1'b0);
            checks++; if (rd_data !== mtbl[mfront][i]) begin fails++; $display("[TB] FAIL b2b_rec%0d: got %h expected %h", i, rd_data, mtbl[mfront][i]); end
        end
        div = 1;
    endtask

    task automatic test_reset_mid();
        int n;
        fill_ram();
        vb_rise();
        ack($urandom_range(0, 5));
        tick();
        tick();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busrq_n !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_busrq_n: got %b expected 1", bus.busrq_n); end
        checks++; if (bus.dma_cs !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_dma_cs: got %b expected 0", bus.dma_cs); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (rd_data !== '0) begin fails++; $display("[TB] FAIL rstmid_rd_data: got %h expected 0", rd_data); end
        rst = 1'b0;
        bus.busak_n = 1'b1;
        VB = 1'b0;
        mfront = 0;
        fill_ram();
        vb_rise();
        ack($urandom_range(0, 5));
        wait_rel(n);
        checks++; if (n != NB + 1) begin fails++; $display("[TB] FAIL rstmid_hold: ticks got %0d expected %0d", n, NB + 1); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_err: got %b expected 0", err); end
        bus.busak_n = 1'b1;
        tick();
        model_frame(N, 1'b1);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            cyc(1'b0);
            checks++; if (rd_data !== mtbl[mfront][i]) begin fails++; $display("[TB] FAIL rstmid_rec%0d: got %h expected %h", i, rd_data, mtbl[mfront][i]); end
        end
    endtask

    task automatic test_clock_enable();
        int n;
        div = 4;
        fill_ram();
        addrq.delete();
        vb_rise();
        addr_glitch = 1'b0;
        ack($urandom_range(0, 5));
        wait_rel(n);
        checks++; if (n != NB + 1) begin fails++; $display("[TB] FAIL cen_hold: ticks got %0d expected %0d", n, NB + 1); end
        checks++; if (!addr_seq_ok()) begin fails++; $display("[TB] FAIL cen_addr: %0d addresses, expected %0d", addrq.size(), NB); end
        checks++; if (addr_glitch) begin fails++; $display("[TB] FAIL cen_addr_stable: address moved between ticks (got 1, expected 0)"); end
        bus.busak_n = 1'b1;
        tick();
        model_frame(N, 1'b1);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            cyc(1'b0);
            checks++; if (rd_data !== mtbl[mfront][i]) begin fails++; $display("[TB] FAIL cen_rec%0d: got %h expected %h", i, rd_data, mtbl[mfront][i]); end
        end
        div = 1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ack_timeout();
        test_vb_abort();
        test_back_to_back();
        test_reset_mid();
        test_clock_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
